// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
//
// Purpose : Encodings and default widths used by the per-core scheduler and
//           the instruction fetcher. Both blocks import this package, so the
//           state values they exchange are defined once.
// Contents: core_state_t    - scheduler state seen by the fetcher
//           fetcher_state_t - fetcher progress reported back to the scheduler
//           DEFAULT_*       - default program-memory address/data widths
// ---------------------------------------------------------------------------
package gpu_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 16;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/icache_array.sv
// ---------------------------------------------------------------------------
// icache_array
//
// Purpose : Direct-mapped instruction cache storage with one instruction per
//           line. The lookup is purely combinational, so the fetcher can
//           resolve a hit in the same cycle it sees FETCH. Writes and flushes
//           take effect on the clock edge.
//
// Ports   : clk          - clock
//           reset        - asynchronous active-low reset; clears valid bits
//           lookup_addr  - address being looked up (full PC)
//           lookup_hit   - line at the lookup index is valid with a matching tag
//           lookup_data  - data held in the line at the lookup index
//           write_en     - install write_data for write_addr on this edge
//           write_addr   - address of the line being installed
//           write_data   - instruction being installed
//           flush        - clear every valid bit on this edge (wins over write)
// ---------------------------------------------------------------------------
module icache_array
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int LINES     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 lookup_hit,
  output logic [DATA_BITS-1:0] lookup_data,
  input  logic                 write_en,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic                 flush
);

  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [LINES-1:0]     valid;
  logic [TAG_BITS-1:0]  tags  [LINES];
  logic [DATA_BITS-1:0] data  [LINES];

  logic [INDEX_BITS-1:0] lookup_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [INDEX_BITS-1:0] write_index;
  logic [TAG_BITS-1:0]   write_tag;

  // Low PC bits select the line, the remaining upper bits form the tag.
  assign lookup_index = lookup_addr[INDEX_BITS-1:0];
  assign lookup_tag   = lookup_addr[ADDR_BITS-1:INDEX_BITS];
  assign write_index  = write_addr[INDEX_BITS-1:0];
  assign write_tag    = write_addr[ADDR_BITS-1:INDEX_BITS];

  assign lookup_hit  = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
  assign lookup_data = data[lookup_index];

  // Valid bits are the only state needing reset. Flush outranks a fill on the
  // same edge so a kernel launch never sees a line from the previous kernel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (write_en) begin
      valid[write_index] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless until the matching valid bit is set,
  // so they are left without reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tags[write_index] <= write_tag;
      data[write_index] <= write_data;
    end
  end

endmodule

// File: rtl/cached_fetcher.sv
// ---------------------------------------------------------------------------
// cached_fetcher
//
// Purpose : Instruction-fetch stage feeding the per-core scheduler. When the
//           scheduler enters FETCH, the instruction at current_pc is returned
//           either from the direct-mapped instruction cache (one cycle) or
//           from program memory (memory latency + 1 cycle). Saturating
//           hit/miss counters support performance bring-up.
//
// Ports   : clk              - clock
//           reset            - asynchronous active-low reset
//           core_state       - scheduler state (acts on FETCH and DECODE)
//           current_pc       - fetch address, sampled only while IDLE
//           flush            - one-cycle pulse invalidating every cache line
//           mem_read_valid   - program-memory read request
//           mem_read_address - program-memory read address
//           mem_read_ready   - read data is valid this cycle
//           mem_read_data    - read data
//           fetcher_state    - IDLE / FETCHING / FETCHED
//           instruction      - last fetched instruction, held until replaced
//           hit_count        - saturating cache-hit count
//           miss_count       - saturating cache-miss count
// ---------------------------------------------------------------------------
module cached_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
  parameter int CACHE_LINES           = 8,
  parameter int COUNTER_BITS          = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNTER_BITS-1:0]          hit_count,
  output logic [COUNTER_BITS-1:0]          miss_count
);

  fetcher_state_t state;
  logic           discard;

  logic                             cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;
  logic                             fill_en;

  // Counters stop at all-ones so a long run never reads back as a small value.
  function automatic logic [COUNTER_BITS-1:0] sat_inc(input logic [COUNTER_BITS-1:0] value);
    return (value == '1) ? value : value + COUNTER_BITS'(1);
  endfunction

  // A fill is installed on the ready cycle unless a flush arrived at any
  // point during this miss (earlier: discard flag; now: flush itself).
  // mem_read_address is held stable for the whole miss, so it doubles as the
  // fill address and later current_pc changes cannot corrupt the line.
  assign fill_en = (state == FETCHER_FETCHING) && mem_read_ready && !discard && !flush;

  icache_array #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) cache (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (current_pc),
    .lookup_hit  (cache_hit),
    .lookup_data (cache_data),
    .write_en    (fill_en),
    .write_addr  (mem_read_address),
    .write_data  (mem_read_data),
    .flush       (flush)
  );

  assign fetcher_state = state;

  // Fetch state machine, memory handshake, discard flag and counters. The
  // async reset drops mem_read_valid immediately, even mid-miss. The lookup
  // in IDLE sees the valid bits from before any same-cycle flush, so a hit
  // coinciding with a kernel-launch flush is still served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= FETCHER_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
      discard          <= 1'b0;
    end else begin
      case (state)
        FETCHER_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (cache_hit) begin
              instruction <= cache_data;
              hit_count   <= sat_inc(hit_count);
              state       <= FETCHER_FETCHED;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              miss_count       <= sat_inc(miss_count);
              state            <= FETCHER_FETCHING;
            end
          end
        end

        FETCHER_FETCHING: begin
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            discard        <= 1'b0;
            state          <= FETCHER_FETCHED;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end

        FETCHER_FETCHED: begin
          if (core_state == CORE_DECODE) begin
            state <= FETCHER_IDLE;
          end
        end

        default: begin
          state          <= FETCHER_IDLE;
          mem_read_valid <= 1'b0;
          discard        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cached_fetcher.sv
// ---------------------------------------------------------------------------
// tb_cached_fetcher
//
// Purpose : Self-checking bench for cached_fetcher. Two instances share every
//           input: one with default 16-bit counters and one with 2-bit
//           counters so saturation is observed alongside normal operation.
//           Expected behaviour comes from a line-by-line cache model that
//           remembers which full PC each line holds, plus a program-memory
//           image owned by the bench.
// ---------------------------------------------------------------------------
module tb_cached_fetcher;
  import gpu_pkg::*;

  localparam int LINES = 8;

  logic        clk;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;

  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic        sat_mem_read_valid;
  logic [7:0]  sat_mem_read_address;
  logic [2:0]  sat_fetcher_state;
  logic [15:0] sat_instruction;
  logic [1:0]  sat_hit_count;
  logic [1:0]  sat_miss_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] prog_mem [256];
  logic        m_valid [LINES];
  logic [7:0]  m_pc    [LINES];
  int          m_hits;
  int          m_misses;

  cached_fetcher dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  cached_fetcher #(.COUNTER_BITS(2)) dut_sat (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .flush            (flush),
    .mem_read_valid   (sat_mem_read_valid),
    .mem_read_address (sat_mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (sat_fetcher_state),
    .instruction      (sat_instruction),
    .hit_count        (sat_hit_count),
    .miss_count       (sat_miss_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sat(input int value, input int max_value);
    return (value > max_value) ? max_value : value;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] cs, input logic [7:0] pc, input logic fl,
                               input logic rdy, input logic [15:0] data);
    core_state     = cs;
    current_pc     = pc;
    flush          = fl;
    mem_read_ready = rdy;
    mem_read_data  = data;
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model_lines();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    checkOutput({tag, "_hits"},       hit_count,      sat(m_hits, 65535));
    checkOutput({tag, "_misses"},     miss_count,     sat(m_misses, 65535));
    checkOutput({tag, "_hits_sat"},   sat_hit_count,  sat(m_hits, 3));
    checkOutput({tag, "_misses_sat"}, sat_miss_count, sat(m_misses, 3));
  endtask

  task automatic do_reset();
    applyStimulus(CORE_IDLE, 8'h00, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    step();
    step();
    checkOutput("rst_state",    fetcher_state,    FETCHER_IDLE);
    checkOutput("rst_valid",    mem_read_valid,   0);
    checkOutput("rst_addr",     mem_read_address, 0);
    checkOutput("rst_instr",    instruction,      0);
    checkOutput("rst_hits",     hit_count,        0);
    checkOutput("rst_misses",   miss_count,       0);
    reset = 1'b1;
    clear_model_lines();
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One complete fetch: FETCH in IDLE, optional memory round trip of 'lat'
  // cycles, hold in FETCHED, DECODE back to IDLE. flush_at = 0 pulses flush
  // alongside FETCH; flush_at = k (1..lat) pulses it in the k-th FETCHING
  // cycle, where k == lat is the ready cycle; negative means no flush.
  task automatic run_fetch(input logic [7:0] pc, input int lat, input int flush_at,
                           output logic dut_hit);
    int          idx;
    logic        exp_hit;
    logic [15:0] exp_instr;
    idx       = int'(pc) % LINES;
    exp_hit   = m_valid[idx] && (m_pc[idx] == pc);
    exp_instr = prog_mem[pc];

    applyStimulus(CORE_FETCH, pc, flush_at == 0, 1'b0, 16'($urandom));
    step();
    dut_hit = (fetcher_state == FETCHER_FETCHED);
    if (flush_at == 0) clear_model_lines();

    if (exp_hit) begin
      m_hits++;
      checkOutput("hit_state",   fetcher_state,  FETCHER_FETCHED);
      checkOutput("hit_no_read", mem_read_valid, 0);
    end else begin
      m_misses++;
      checkOutput("miss_state", fetcher_state,    FETCHER_FETCHING);
      checkOutput("miss_req",   mem_read_valid,   1);
      checkOutput("miss_addr",  mem_read_address, pc);
      checkOutput("miss_addr_sat", sat_mem_read_address, pc);
      for (int c = 1; c <= lat; c++) begin
        applyStimulus(CORE_FETCH, 8'($urandom), flush_at == c, c == lat,
                      (c == lat) ? exp_instr : 16'($urandom));
        step();
        if (c < lat) begin
          checkOutput("wait_state", fetcher_state,    FETCHER_FETCHING);
          checkOutput("wait_req",   mem_read_valid,   1);
          checkOutput("wait_addr",  mem_read_address, pc);
        end
      end
      if (flush_at >= 1) begin
        clear_model_lines();
      end else begin
        m_valid[idx] = 1'b1;
        m_pc[idx]    = pc;
      end
      checkOutput("fill_state",   fetcher_state,      FETCHER_FETCHED);
      checkOutput("fill_req_off", mem_read_valid,     0);
      checkOutput("fill_req_sat", sat_mem_read_valid, 0);
    end
    checkOutput("fetched_instr",     instruction,       exp_instr);
    checkOutput("fetched_instr_sat", sat_instruction,   exp_instr);
    checkOutput("fetched_state_sat", sat_fetcher_state, FETCHER_FETCHED);
    check_counters("fetch");

    // Neither a foreign scheduler state nor a new PC disturbs FETCHED.
    applyStimulus(CORE_EXECUTE, 8'($urandom), 1'b0, 1'b0, 16'($urandom));
    step();
    checkOutput("hold_state", fetcher_state, FETCHER_FETCHED);
    checkOutput("hold_instr", instruction,   exp_instr);

    applyStimulus(CORE_DECODE, 8'($urandom), 1'b0, 1'b0, 16'($urandom));
    step();
    checkOutput("decode_state", fetcher_state, FETCHER_IDLE);
    checkOutput("decode_instr", instruction,   exp_instr);

    applyStimulus(CORE_WAIT, 8'($urandom), 1'b0, 1'b0, 16'($urandom));
    step();
    checkOutput("idle_state",   fetcher_state,  FETCHER_IDLE);
    checkOutput("idle_no_read", mem_read_valid, 0);
    checkOutput("idle_instr",   instruction,    exp_instr);
    applyStimulus(CORE_IDLE, 8'h00, 1'b0, 1'b0, 16'h0000);
  endtask

  typedef struct {
    logic       do_reset;
    logic [7:0] pc;
    int         lat;
    int         flush_at;
    logic       exp_hit;
    int         exp_hits;
    int         exp_misses;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic dut_hit;
    int   r;
    int   lat;
    int   flush_at;
    logic [7:0] pc;

    reset = 1'b0;
    applyStimulus(CORE_IDLE, 8'h00, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 256; i++) prog_mem[i] = 16'($urandom);
    prog_mem[8'h05] = 16'h1234;
    prog_mem[8'h0D] = 16'hBEEF;
    prog_mem[8'h07] = 16'h7777;
    clear_model_lines();
    for (int i = 0; i < LINES; i++) m_pc[i] = 8'h00;
    m_hits   = 0;
    m_misses = 0;

    //            rst   pc     lat flush hit   hits misses
    vecs[0]  = '{1'b1, 8'h05, 3, -1, 1'b0, 0, 1};  // cold miss, 3-cycle memory
    vecs[1]  = '{1'b0, 8'h05, 1, -1, 1'b1, 1, 1};  // warm hit
    vecs[2]  = '{1'b1, 8'h05, 2, -1, 1'b0, 0, 1};  // conflict: 05 / 0D / 05
    vecs[3]  = '{1'b0, 8'h0D, 2, -1, 1'b0, 0, 2};
    vecs[4]  = '{1'b0, 8'h05, 3, -1, 1'b0, 0, 3};
    vecs[5]  = '{1'b0, 8'h0D, 1, -1, 1'b0, 0, 4};
    vecs[6]  = '{1'b1, 8'h07, 3,  2, 1'b0, 0, 1};  // flush mid-fill discards line
    vecs[7]  = '{1'b0, 8'h07, 2, -1, 1'b0, 0, 2};
    vecs[8]  = '{1'b0, 8'h07, 1, -1, 1'b1, 1, 2};
    vecs[9]  = '{1'b0, 8'h07, 1,  0, 1'b1, 2, 2};  // flush with FETCH: pre-flush hit
    vecs[10] = '{1'b0, 8'h07, 2,  2, 1'b0, 2, 3};  // flush on the ready cycle
    vecs[11] = '{1'b0, 8'h07, 1,  0, 1'b0, 2, 4};  // flush before a miss still fills
    vecs[12] = '{1'b0, 8'h07, 1, -1, 1'b1, 3, 4};
    vecs[13] = '{1'b0, 8'h07, 1, -1, 1'b1, 4, 4};
    vecs[14] = '{1'b0, 8'h07, 1, -1, 1'b1, 5, 4};
    vecs[15] = '{1'b0, 8'h07, 1, -1, 1'b1, 6, 4};
    vecs[16] = '{1'b0, 8'h07, 1, -1, 1'b1, 7, 4};

    $display("[TB] directed vectors");
    for (int v = 0; v < 17; v++) begin
      if (vecs[v].do_reset) do_reset();
      run_fetch(vecs[v].pc, vecs[v].lat, vecs[v].flush_at, dut_hit);
      checkOutput($sformatf("vec%0d_hit", v),      dut_hit,        vecs[v].exp_hit);
      checkOutput($sformatf("vec%0d_hits", v),     hit_count,      vecs[v].exp_hits);
      checkOutput($sformatf("vec%0d_misses", v),   miss_count,     vecs[v].exp_misses);
      checkOutput($sformatf("vec%0d_hits_sat", v), sat_hit_count,  sat(vecs[v].exp_hits, 3));
    end

    // Asynchronous reset in the middle of a miss.
    $display("[TB] reset during FETCHING");
    do_reset();
    applyStimulus(CORE_FETCH, 8'h20, 1'b0, 1'b0, 16'h0000);
    step();
    checkOutput("midrst_req_before", mem_read_valid, 1);
    applyStimulus(CORE_FETCH, 8'h20, 1'b0, 1'b0, 16'h0000);
    step();
    #3 reset = 1'b0;
    #1;
    checkOutput("midrst_req_dropped", mem_read_valid, 0);
    checkOutput("midrst_state_idle",  fetcher_state,  FETCHER_IDLE);
    checkOutput("midrst_misses",      miss_count,     0);
    step();
    reset = 1'b1;
    clear_model_lines();
    m_hits   = 0;
    m_misses = 0;
    run_fetch(8'h20, 2, -1, dut_hit);
    checkOutput("midrst_refetch_miss", dut_hit,    0);
    checkOutput("midrst_refetch_cnt",  miss_count, 1);

    // Randomized fetch stream over a small PC range so hits, conflicts and
    // flushes all occur often.
    $display("[TB] randomized fetches");
    do_reset();
    for (int n = 0; n < 150; n++) begin
      pc  = 8'($urandom_range(0, 23));
      lat = $urandom_range(1, 4);
      r   = $urandom_range(0, 5);
      if (r == 0)      flush_at = 0;
      else if (r == 1) flush_at = $urandom_range(1, lat);
      else             flush_at = -1;
      run_fetch(pc, lat, flush_at, dut_hit);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
